// File: rtl/text_ram_scheduler_pkg.sv
// Shared definitions for the text RAM scheduler: slot owners, clear FSM
// state codes, RAM address width and default clear fill character.
// No ports; imported by text_ram_scheduler and text_ram_scheduler_clear_engine.
package text_ram_scheduler_pkg;

   localparam int ADDR_W  = 14;   // {line[6:0], col[6:0]}
   localparam int COORD_W = 7;    // width of one line or column coordinate

   localparam logic [7:0] BLANK_DEFAULT = 8'h20;

   // Owner of one RAM cycle
   typedef enum logic [1:0] {
      OWN_IDLE    = 2'd0,
      OWN_DISPLAY = 2'd1,
      OWN_HOST    = 2'd2,
      OWN_CLEAR   = 2'd3
   } owner_t;

   // Clear FSM state encoding
   localparam logic [1:0] CLR_IDLE = 2'd0;
   localparam logic [1:0] CLR_RUN  = 2'd1;
   localparam logic [1:0] CLR_DONE = 2'd2;

endpackage

// File: rtl/text_ram_scheduler_clear_engine.sv
// Clear engine: walks every {line,col} cell once, one cell per grant.
// Latency: start -> RUN next cycle; each grant advances the cell counter.
// Backpressure: waits indefinitely for grant while requesting.
// Ports: clk/reset, start (ignored unless idle), grant, req (RUN),
//        busy (RUN or DONE), done (one-cycle pulse), addr (current cell).
module text_ram_scheduler_clear_engine
   import text_ram_scheduler_pkg::*;
#(
   parameter int COLS = 100,
   parameter int ROWS = 75
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              grant,
   output logic              req,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] addr
);

   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(COLS - 1);
   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(ROWS - 1);

   logic [1:0]         state;
   logic [COORD_W-1:0] line;
   logic [COORD_W-1:0] col;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= CLR_IDLE;
         line  <= '0;
         col   <= '0;
      end else begin
         case (state)
            CLR_IDLE: begin
               if (start) begin
                  state <= CLR_RUN;
                  line  <= '0;
                  col   <= '0;
               end
            end
            CLR_RUN: begin
               if (grant) begin
                  if (col == LAST_COL) begin
                     col <= '0;
                     // Last cell granted: the write lands alongside DONE
                     if (line == LAST_ROW) state <= CLR_DONE;
                     else                  line  <= line + 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            CLR_DONE: state <= CLR_IDLE;
            default:  state <= CLR_IDLE;
         endcase
      end
   end

   assign req  = (state == CLR_RUN);
   assign busy = (state == CLR_RUN) || (state == CLR_DONE);
   assign done = (state == CLR_DONE);
   assign addr = {line, col};

endmodule

// File: rtl/text_ram_scheduler.sv
// Single-port text RAM scheduler: display reads always win, host and clear
// writes share the remaining slots round-robin. Latency: slot decided in
// cycle N drives RAM outputs in N+1. Backpressure: host holds req until ack.
// Ports: pixel_clock/reset; char_column/char_line/subchar_pixel/blank from
//        the timing generator; host_req/addr/data/ack write port;
//        clear_start/busy/done; registered RAM strobes ram_*; disp_rd.
module text_ram_scheduler
   import text_ram_scheduler_pkg::*;
#(
   parameter int         COLS       = 100,
   parameter int         ROWS       = 75,
   parameter logic [7:0] BLANK_CODE = BLANK_DEFAULT
)(
   input  logic              pixel_clock,
   input  logic              reset,
   input  logic [6:0]        char_column,
   input  logic [6:0]        char_line,
   input  logic [2:0]        subchar_pixel,
   input  logic              blank,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [7:0]        host_data,
   output logic              host_ack,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              disp_rd
);

   localparam logic [COORD_W-1:0] COLS_L = COORD_W'(COLS);
   localparam logic [COORD_W-1:0] ROWS_L = COORD_W'(ROWS);

   logic              display_slot;
   logic              host_want;
   logic              host_in_range;
   logic              clr_req;
   logic [ADDR_W-1:0] clr_addr;
   owner_t            owner;
   owner_t            last_writer;

   assign display_slot = !blank && (subchar_pixel == 3'd0);
   // The host still shows req during its ack cycle; it must not be re-granted then
   assign host_want     = host_req && !host_ack;
   assign host_in_range = (host_addr[6:0] < COLS_L) && (host_addr[13:7] < ROWS_L);

   always_comb begin
      owner = OWN_IDLE;
      if (display_slot)
         owner = OWN_DISPLAY;
      else if (host_want && clr_req)
         owner = (last_writer == OWN_HOST) ? OWN_CLEAR : OWN_HOST;
      else if (host_want)
         owner = OWN_HOST;
      else if (clr_req)
         owner = OWN_CLEAR;
   end

   text_ram_scheduler_clear_engine #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_clear_engine (
      .clk   (pixel_clock),
      .reset (reset),
      .start (clear_start),
      .grant (owner == OWN_CLEAR),
      .req   (clr_req),
      .busy  (clear_busy),
      .done  (clear_done),
      .addr  (clr_addr)
   );

   // Round-robin pointer; resets to CLEAR so the host wins first contention
   always_ff @(posedge pixel_clock or posedge reset) begin
      if (reset)
         last_writer <= OWN_CLEAR;
      else if (owner == OWN_HOST || owner == OWN_CLEAR)
         last_writer <= owner;
   end

   // RAM output register: strobes are single-cycle, address/data hold
   always_ff @(posedge pixel_clock or posedge reset) begin
      if (reset) begin
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         disp_rd   <= 1'b0;
         host_ack  <= 1'b0;
      end else begin
         ram_en   <= 1'b0;
         ram_we   <= 1'b0;
         disp_rd  <= 1'b0;
         host_ack <= 1'b0;
         case (owner)
            OWN_DISPLAY: begin
               ram_en   <= 1'b1;
               ram_addr <= {char_line, char_column};
               disp_rd  <= 1'b1;
            end
            OWN_HOST: begin
               // Off-screen writes are acknowledged but never reach the RAM
               ram_en    <= host_in_range;
               ram_we    <= host_in_range;
               ram_addr  <= host_addr;
               ram_wdata <= host_data;
               host_ack  <= 1'b1;
            end
            OWN_CLEAR: begin
               ram_en    <= 1'b1;
               ram_we    <= 1'b1;
               ram_addr  <= clr_addr;
               ram_wdata <= BLANK_CODE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_text_ram_scheduler.sv
// Directed self-checking bench for text_ram_scheduler.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Ports: all DUT ports connected by name.
module tb_text_ram_scheduler;

   logic        pixel_clock = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  char_column = '0;
   logic [6:0]  char_line = '0;
   logic [2:0]  subchar_pixel = '0;
   logic        blank = 1'b1;
   logic        host_req = 1'b0;
   logic [13:0] host_addr = '0;
   logic [7:0]  host_data = '0;
   logic        host_ack;
   logic        clear_start = 1'b0;
   logic        clear_busy;
   logic        clear_done;
   logic        ram_en;
   logic        ram_we;
   logic [13:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        disp_rd;

   int checks = 0;
   int errors = 0;

   text_ram_scheduler dut (
      .pixel_clock   (pixel_clock),
      .reset         (reset),
      .char_column   (char_column),
      .char_line     (char_line),
      .subchar_pixel (subchar_pixel),
      .blank         (blank),
      .host_req      (host_req),
      .host_addr     (host_addr),
      .host_data     (host_data),
      .host_ack      (host_ack),
      .clear_start   (clear_start),
      .clear_busy    (clear_busy),
      .clear_done    (clear_done),
      .ram_en        (ram_en),
      .ram_we        (ram_we),
      .ram_addr      (ram_addr),
      .ram_wdata     (ram_wdata),
      .disp_rd       (disp_rd)
   );

   always #5 pixel_clock = ~pixel_clock;

   task automatic tick;
      @(posedge pixel_clock);
      #1;
   endtask

   task automatic test_reset;
      tick;
      tick;
      checks++;
      if ({ram_en, ram_we, disp_rd, host_ack, clear_busy, clear_done} !== 6'b0) begin
         errors++;
         $display("FAIL reset_strobes got en=%b we=%b rd=%b ack=%b busy=%b done=%b want all 0",
                  ram_en, ram_we, disp_rd, host_ack, clear_busy, clear_done);
      end
      checks++;
      if (ram_addr !== 14'h0000) begin
         errors++;
         $display("FAIL reset_addr got %h want 0000", ram_addr);
      end
      checks++;
      if (ram_wdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_wdata got %h want 00", ram_wdata);
      end
      reset = 1'b0;
      tick;
      checks++;
      if (ram_en !== 1'b0 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL idle_slot got en=%b we=%b want 0 0", ram_en, ram_we);
      end
   endtask

   task automatic test_host_blank;
      blank = 1'b1;
      host_addr = 14'h0102;
      host_data = 8'h41;
      host_req = 1'b1;
      tick;
      checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 14'h0102 ||
          ram_wdata !== 8'h41 || host_ack !== 1'b1) begin
         errors++;
         $display("FAIL host_write got en=%b we=%b addr=%h data=%h ack=%b want 1 1 0102 41 1",
                  ram_en, ram_we, ram_addr, ram_wdata, host_ack);
      end
      host_req = 1'b0;
      tick;
      checks++;
      if (host_ack !== 1'b0 || ram_en !== 1'b0) begin
         errors++;
         $display("FAIL host_ack_pulse got ack=%b en=%b want 0 0", host_ack, ram_en);
      end
   endtask

   task automatic test_display_priority;
      blank = 1'b0;
      subchar_pixel = 3'd0;
      char_line = 7'd3;
      char_column = 7'd5;
      host_addr = 14'h0203;
      host_data = 8'h55;
      host_req = 1'b1;
      tick;
      checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 14'h0185 ||
          disp_rd !== 1'b1 || host_ack !== 1'b0) begin
         errors++;
         $display("FAIL display_slot got en=%b we=%b addr=%h rd=%b ack=%b want 1 0 0185 1 0",
                  ram_en, ram_we, ram_addr, disp_rd, host_ack);
      end
      subchar_pixel = 3'd1;
      tick;
      checks++;
      if (host_ack !== 1'b1 || ram_we !== 1'b1 || ram_en !== 1'b1 ||
          ram_addr !== 14'h0203 || ram_wdata !== 8'h55 || disp_rd !== 1'b0) begin
         errors++;
         $display("FAIL host_after_display got ack=%b we=%b en=%b addr=%h data=%h rd=%b want 1 1 1 0203 55 0",
                  host_ack, ram_we, ram_en, ram_addr, ram_wdata, disp_rd);
      end
      host_req = 1'b0;
      blank = 1'b1;
      subchar_pixel = 3'd0;
      tick;
      checks++;
      if (host_ack !== 1'b0 || disp_rd !== 1'b0) begin
         errors++;
         $display("FAIL display_release got ack=%b rd=%b want 0 0", host_ack, disp_rd);
      end
   endtask

   task automatic test_out_of_range;
      logic [13:0] addrs [3];
      logic        exp_en [3];
      addrs[0] = 14'h00E4; exp_en[0] = 1'b0;   // line 1, col 100
      addrs[1] = 14'h2580; exp_en[1] = 1'b0;   // line 75, col 0
      addrs[2] = 14'h2563; exp_en[2] = 1'b1;   // line 74, col 99
      blank = 1'b1;
      for (int i = 0; i < 3; i++) begin
         host_addr = addrs[i];
         host_data = 8'h33;
         host_req = 1'b1;
         tick;
         checks++;
         if (host_ack !== 1'b1 || ram_en !== exp_en[i] || ram_we !== exp_en[i]) begin
            errors++;
            $display("FAIL range_%0d addr=%h got ack=%b en=%b we=%b want 1 %b %b",
                     i, addrs[i], host_ack, ram_en, ram_we, exp_en[i], exp_en[i]);
         end
         host_req = 1'b0;
         tick;
      end
   endtask

   task automatic test_clear_full;
      int          nwr = 0;
      int          nbad = 0;
      int          ndone = 0;
      int          done_idx = -1;
      int          last_cyc = 0;
      int          ngaps = 0;
      logic [6:0]  el = '0;
      logic [6:0]  ec = '0;
      logic [13:0] last_a = '0;
      bit          finished = 1'b0;
      blank = 1'b1;
      host_req = 1'b0;
      clear_start = 1'b1;
      tick;
      clear_start = 1'b0;
      checks++;
      if (clear_busy !== 1'b1 || ram_en !== 1'b0) begin
         errors++;
         $display("FAIL clear_start got busy=%b en=%b want 1 0", clear_busy, ram_en);
      end
      for (int c = 0; c < 8000; c++) begin
         tick;
         if (ram_en === 1'b1) begin
            if (ram_addr !== {el, ec} || ram_we !== 1'b1 || ram_wdata !== 8'h20) nbad++;
            if (nwr > 0 && c != last_cyc + 1) ngaps++;
            last_cyc = c;
            last_a = ram_addr;
            nwr++;
            if (ec == 7'd99) begin
               ec = '0;
               el = el + 7'd1;
            end else begin
               ec = ec + 7'd1;
            end
         end
         if (clear_done === 1'b1) begin
            ndone++;
            done_idx = nwr;
         end
         if (clear_busy !== 1'b1) begin
            finished = 1'b1;
            break;
         end
      end
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL clear_timeout got busy=%b want 0 within 8000 cycles", clear_busy);
      end
      checks++;
      if (nwr != 7500 || nbad != 0 || ngaps != 0) begin
         errors++;
         $display("FAIL clear_writes got count=%0d bad=%0d gaps=%0d want 7500 0 0", nwr, nbad, ngaps);
      end
      checks++;
      if (last_a !== 14'h2563) begin
         errors++;
         $display("FAIL clear_last_addr got %h want 2563", last_a);
      end
      checks++;
      if (ndone != 1 || done_idx != 7500) begin
         errors++;
         $display("FAIL clear_done_pulse got pulses=%0d at_write=%0d want 1 7500", ndone, done_idx);
      end
      checks++;
      if (clear_done !== 1'b0 || ram_en !== 1'b0) begin
         errors++;
         $display("FAIL clear_idle_after got done=%b en=%b want 0 0", clear_done, ram_en);
      end
   endtask

   task automatic test_alternation;
      logic        exp_host;
      logic [13:0] exp_addr;
      logic [7:0]  exp_data;
      blank = 1'b1;
      host_addr = 14'h0300;
      host_data = 8'h77;
      host_req = 1'b1;
      clear_start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick;
         clear_start = 1'b0;
         exp_host = (i % 2 == 0);
         exp_addr = exp_host ? 14'h0300 : 14'((i - 1) / 2);
         exp_data = exp_host ? 8'h77 : 8'h20;
         checks++;
         if (host_ack !== exp_host || ram_en !== 1'b1 || ram_we !== 1'b1 ||
             ram_addr !== exp_addr || ram_wdata !== exp_data) begin
            errors++;
            $display("FAIL alternate_%0d got ack=%b en=%b we=%b addr=%h data=%h want %b 1 1 %h %h",
                     i, host_ack, ram_en, ram_we, ram_addr, ram_wdata, exp_host, exp_addr, exp_data);
         end
      end
      host_req = 1'b0;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      tick;
      checks++;
      if (clear_busy !== 1'b0) begin
         errors++;
         $display("FAIL alternate_abort got busy=%b want 0", clear_busy);
      end
   endtask

   task automatic test_reset_mid_clear;
      bit found = 1'b0;
      bit saw_done = 1'b0;
      blank = 1'b1;
      host_req = 1'b0;
      clear_start = 1'b1;
      tick;
      clear_start = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         tick;
         if (clear_done === 1'b1) saw_done = 1'b1;
         if (ram_en === 1'b1 && ram_addr === 14'h0A10) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_clear_reach got addr=%h want 0a10 within 3000 cycles", ram_addr);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({ram_en, ram_we, disp_rd, host_ack, clear_busy, clear_done} !== 6'b0 ||
          ram_addr !== 14'h0000 || ram_wdata !== 8'h00) begin
         errors++;
         $display("FAIL async_reset got en=%b we=%b rd=%b ack=%b busy=%b done=%b addr=%h data=%h want all 0",
                  ram_en, ram_we, disp_rd, host_ack, clear_busy, clear_done, ram_addr, ram_wdata);
      end
      host_addr = 14'h0005;
      host_data = 8'h11;
      host_req = 1'b1;
      tick;
      if (clear_done === 1'b1) saw_done = 1'b1;
      tick;
      if (clear_done === 1'b1) saw_done = 1'b1;
      checks++;
      if (host_ack !== 1'b0) begin
         errors++;
         $display("FAIL ack_in_reset got %b want 0", host_ack);
      end
      reset = 1'b0;
      tick;
      if (clear_done === 1'b1) saw_done = 1'b1;
      checks++;
      if (host_ack !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 14'h0005 || ram_wdata !== 8'h11) begin
         errors++;
         $display("FAIL host_after_reset got ack=%b en=%b addr=%h data=%h want 1 1 0005 11",
                  host_ack, ram_en, ram_addr, ram_wdata);
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL aborted_no_done got done seen=1 want 0");
      end
      host_req = 1'b0;
      tick;
      clear_start = 1'b1;
      tick;
      clear_start = 1'b0;
      tick;
      checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 14'h0000 || ram_wdata !== 8'h20) begin
         errors++;
         $display("FAIL clear_restart got en=%b we=%b addr=%h data=%h want 1 1 0000 20",
                  ram_en, ram_we, ram_addr, ram_wdata);
      end
      reset = 1'b1;
      tick;
      reset = 1'b0;
   endtask

   initial begin
      test_reset;
      test_host_blank;
      test_display_priority;
      test_out_of_range;
      test_clear_full;
      test_alternation;
      test_reset_mid_clear;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/text_ram_scheduler.md
TEXT_RAM_SCHEDULER -- requirements
Module: text_ram_scheduler

Interface
REQ-001 SHALL have parameters COLS (default 100, characters per line), ROWS (default 75, lines per screen) and BLANK_CODE (default 8'h20, clear fill character).
REQ-002 SHALL have port pixel_clock, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports char_column, input, 7, and char_line, input, 7, giving the current character cell from the timing generator.
REQ-005 SHALL have ports subchar_pixel, input, 3, pixel within the cell, and blank, input, 1, composite blanking.
REQ-006 SHALL have host write ports: host_req input 1; host_addr input 14 ({line[6:0],col[6:0]}); host_data input 8; host_ack output 1.
REQ-007 SHALL have clear ports: clear_start input 1; clear_busy output 1; clear_done output 1.
REQ-008 SHALL have RAM ports: ram_en output 1; ram_we output 1; ram_addr output 14; ram_wdata output 8.
REQ-009 SHALL have port disp_rd, output, 1, asserted together with a display read.

Function
REQ-010 The RAM is single-port; each cycle SHALL have exactly one slot owner: DISPLAY, HOST, CLEAR or IDLE.
REQ-011 A DISPLAY slot SHALL occur when blank=0 and subchar_pixel=0, with address {char_line,char_column}; DISPLAY SHALL always win.
REQ-012 Every other cycle is a free slot, arbitrated round-robin between HOST and CLEAR; a pointer records the last granted writer, and the other writer wins when both request.
REQ-013 A writer alone requesting in a free slot SHALL be granted that slot.
REQ-014 RAM outputs SHALL be registered: a slot decided in cycle N drives ram_en/ram_we/ram_addr/ram_wdata in cycle N+1 only.
REQ-015 The DISPLAY slot SHALL drive ram_en=1, ram_we=0 and disp_rd=1 for one cycle.
REQ-016 host_ack SHALL pulse for one cycle, coincident with the RAM write strobe; the host holds req/addr/data until ack, and the scheduler SHALL sample address and data only at grant.
REQ-017 A host address with col>=COLS or line>=ROWS SHALL still be acked, with ram_en=0 (write dropped).
REQ-018 Clear FSM states: IDLE, RUN, DONE.
REQ-019 IDLE->RUN on clear_start; counters are cleared to line=0, col=0.
REQ-020 In RUN, each CLEAR grant SHALL write BLANK_CODE to {line,col}, then increment col; col=COLS-1 wraps to 0 with line+1.
REQ-021 The grant for line=ROWS-1, col=COLS-1 SHALL cause RUN->DONE.
REQ-022 DONE SHALL pulse clear_done for one cycle, then return to IDLE.
REQ-023 clear_busy=1 in RUN and DONE; clear_start SHALL be ignored unless the FSM is IDLE.
REQ-024 When a HOST write and CLEAR target the same address, RAM order follows grant order; no merging.
REQ-025 An IDLE slot SHALL drive ram_en=0 and ram_we=0.

Reset
REQ-026 On reset: ram_en, ram_we, disp_rd, host_ack, clear_busy and clear_done SHALL be 0; ram_addr=0; ram_wdata=0; FSM=IDLE; counters=0; round-robin pointer=CLEAR (HOST wins first contention).
REQ-027 Reset mid-clear SHALL abort the clear with no clear_done, and the display SHALL keep partial contents.
REQ-028 A host request pending through reset SHALL receive no ack until re-granted after reset release.

Structure
REQ-029 A shared package SHALL hold the slot-owner enumeration, clear FSM state encoding, the 14-bit address width and the BLANK_CODE default.
REQ-030 The clear FSM plus its line/col counters SHALL be one sub-module, clear_engine; arbitration and the RAM output register stay in the top.

Verification
REQ-031 Bench: blank=0, subchar_pixel=0, char_line=3, char_column=5 while host_req=1 -> cycle N+1 ram_addr=0x0185, ram_we=0, disp_rd=1, no host_ack; the host is granted the next free slot.
REQ-032 Bench: host_req with addr=0x0102 and data=0x41 in blanking -> one cycle later ram_we=1, ram_addr=0x0102, ram_wdata=0x41 and a host_ack pulse.
REQ-033 Bench: clear_start with blank=1 and no host -> 7500 consecutive BLANK_CODE writes ending at addr {74,99}=0x2563, then one clear_done pulse, clear_busy falling with it.
REQ-034 Bench: host_req held during RUN in blanking -> strict alternation of HOST and CLEAR writes.
REQ-035 Bench: host addr col=100 -> host_ack=1, ram_en=0.
REQ-036 Bench: reset asserted at clear address 0x0A10 -> all outputs 0 asynchronously, no clear_done; a new clear_start restarts from 0x0000.
